// File: rtl/exu_pkg.sv
// exu_pkg -- shared types and helpers for the EXU pipeline stage.
//   * ID2EXE_LEN / EXE2MEM_LEN: bus widths. They normally come from the
//     shared macros.h header. The guarded fallbacks below keep this slice
//     self-contained when that header is not part of the build.
//   * id2exe_t: field view of the ID->EXE payload.
//   * store_mask / store_data / misaligned: LSU byte-lane helpers.
`ifndef ID2EXE_LEN
`define ID2EXE_LEN 151
`endif
`ifndef EXE2MEM_LEN
`define EXE2MEM_LEN 75
`endif

package exu_pkg;

    localparam int unsigned ID2EXE_W  = `ID2EXE_LEN;
    localparam int unsigned EXE2MEM_W = `EXE2MEM_LEN;
    localparam int unsigned RF_ZIP_W  = 39;

    // Bit positions inside the one-hot alu_op vector.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLT  = 4'd2,
        OP_SLTU = 4'd3,
        OP_AND  = 4'd4,
        OP_NOR  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef struct packed {
        logic [11:0] alu_op;
        logic        res_from_mem;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [3:0]  mem_op;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rkd_value;
        logic [31:0] pc;
    } id2exe_t;

    function automatic logic [3:0] store_mask(input mem_size_e sz, input logic [1:0] addr_lo);
        case (sz)
            SIZE_BYTE: store_mask = 4'b0001 << addr_lo;
            SIZE_HALF: store_mask = 4'b0011 << {addr_lo[1], 1'b0};
            SIZE_WORD: store_mask = 4'b1111;
            default:   store_mask = 4'b0000;
        endcase
    endfunction

    // Lanes are replicated so the SRAM byte enables alone select the data.
    function automatic logic [31:0] store_data(input mem_size_e sz, input logic [31:0] rkd);
        case (sz)
            SIZE_BYTE: store_data = {4{rkd[7:0]}};
            SIZE_HALF: store_data = {2{rkd[15:0]}};
            default:   store_data = rkd;
        endcase
    endfunction

    function automatic logic misaligned(input mem_size_e sz, input logic [1:0] addr_lo);
        case (sz)
            SIZE_HALF: misaligned = addr_lo[0];
            SIZE_WORD: misaligned = |addr_lo;
            default:   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exu_if.sv
// exu_if -- handshake and data buses around the EXU stage.
//   ID side : id_to_exe_valid, id_to_exe_zip -> EXU; exe_allowin <- EXU
//   MEM side: exe_to_mem_valid, exe_to_mem_zip <- EXU; mem_allowin -> EXU
//   Bypass  : exe_rf_zip {res_from_mem, rf_we, rf_waddr, alu_result}
//   SRAM    : data_sram_en/we/addr/wdata
//   Misc    : exe_ale, one-cycle misaligned-access pulse
// master = the EXU itself, slave = surrounding pipeline / environment.
interface exu_if;
    import exu_pkg::*;

    logic                 exe_allowin;
    logic                 id_to_exe_valid;
    logic [ID2EXE_W-1:0]  id_to_exe_zip;
    logic                 mem_allowin;
    logic                 exe_to_mem_valid;
    logic [EXE2MEM_W-1:0] exe_to_mem_zip;
    logic [RF_ZIP_W-1:0]  exe_rf_zip;
    logic                 exe_ale;
    logic                 data_sram_en;
    logic [3:0]           data_sram_we;
    logic [31:0]          data_sram_addr;
    logic [31:0]          data_sram_wdata;

    modport master (
        output exe_allowin,
        input  id_to_exe_valid,
        input  id_to_exe_zip,
        input  mem_allowin,
        output exe_to_mem_valid,
        output exe_to_mem_zip,
        output exe_rf_zip,
        output exe_ale,
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata
    );

    modport slave (
        input  exe_allowin,
        output id_to_exe_valid,
        output id_to_exe_zip,
        output mem_allowin,
        input  exe_to_mem_valid,
        input  exe_to_mem_zip,
        input  exe_rf_zip,
        input  exe_ale,
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata
    );

endinterface

// File: rtl/exu_alu.sv
// alu -- 32-bit combinational ALU with a one-hot operation select.
//   alu_op[11:0] : one-hot op (add, sub, slt, sltu, and, nor, or, xor,
//                  sll, srl, sra, pass-src2)
//   alu_src1/2   : operands; the shift amount is alu_src2[4:0]
//   alu_result   : result; 0 when alu_op is all zero
module alu
    import exu_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [4:0] shamt;
    assign shamt = alu_src2[4:0];

    // Each op contributes an OR term, so an all-zero select yields zero.
    always_comb begin
        alu_result = '0;
        if (alu_op[OP_ADD])  alu_result = alu_result | (alu_src1 + alu_src2);
        if (alu_op[OP_SUB])  alu_result = alu_result | (alu_src1 - alu_src2);
        if (alu_op[OP_SLT])  alu_result = alu_result | {31'b0, $signed(alu_src1) < $signed(alu_src2)};
        if (alu_op[OP_SLTU]) alu_result = alu_result | {31'b0, alu_src1 < alu_src2};
        if (alu_op[OP_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[OP_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[OP_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[OP_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[OP_SLL])  alu_result = alu_result | (alu_src1 << shamt);
        if (alu_op[OP_SRL])  alu_result = alu_result | (alu_src1 >> shamt);
        if (alu_op[OP_SRA])  alu_result = alu_result | $unsigned($signed(alu_src1) >>> shamt);
        if (alu_op[OP_LUI])  alu_result = alu_result | alu_src2;
    end

endmodule

// File: rtl/exu.sv
// exu -- single-cycle execute stage of the 5-stage pipeline.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : exu_if.master (ID/MEM handshakes, bypass zip, data SRAM, exe_ale)
// Optional feature: define EXU_ALIGN_CHECK_EN to flag misaligned half/word
// accesses. A flagged access issues no SRAM request, loses its register
// write, and pulses exe_ale in the cycle it passes to MEM.
module exu
    import exu_pkg::*;
(
    input  logic   clk,
    input  logic   resetn,
    exu_if.master  bus
);

    logic        exe_valid;
    logic        ready_go;
    id2exe_t     pl;
    logic [31:0] alu_result;
    logic        is_load;
    logic        is_store;
    logic        ale;
    logic        rf_we_eff;
    mem_size_e   size;

    assign ready_go = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exe_valid <= 1'b0;
        end else if (bus.exe_allowin) begin
            exe_valid <= bus.id_to_exe_valid;
        end
    end

    // Payload has no reset: every consumer is qualified by exe_valid.
    always_ff @(posedge clk) begin
        if (bus.id_to_exe_valid && bus.exe_allowin) begin
            pl <= bus.id_to_exe_zip;
        end
    end

    alu u_alu (
        .alu_op     (pl.alu_op),
        .alu_src1   (pl.alu_src1),
        .alu_src2   (pl.alu_src2),
        .alu_result (alu_result)
    );

    assign is_load  = pl.res_from_mem;
    assign is_store = pl.mem_op[2];
    assign size     = mem_size_e'(pl.mem_op[1:0]);

`ifdef EXU_ALIGN_CHECK_EN
    assign ale = (is_load | is_store) & misaligned(size, alu_result[1:0]);
`else
    assign ale = 1'b0;
`endif

    assign rf_we_eff = pl.rf_we & ~ale;

    assign bus.exe_allowin      = ~exe_valid | (ready_go & bus.mem_allowin);
    assign bus.exe_to_mem_valid = exe_valid & ready_go;
    assign bus.exe_to_mem_zip   = {pl.res_from_mem, pl.mem_op, rf_we_eff, pl.rf_waddr,
                                   alu_result, pl.pc};
    assign bus.exe_rf_zip       = {pl.res_from_mem & exe_valid, rf_we_eff & exe_valid,
                                   pl.rf_waddr, alu_result};

    // Requiring mem_allowin means a held instruction issues its request
    // only in the cycle it leaves, never once per stall cycle.
    assign bus.data_sram_en    = exe_valid & bus.mem_allowin & (is_load | is_store) & ~ale;
    assign bus.data_sram_we    = (bus.data_sram_en & is_store) ? store_mask(size, alu_result[1:0])
                                                               : 4'b0000;
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = store_data(size, pl.rkd_value);
    assign bus.exe_ale         = exe_valid & bus.mem_allowin & ale;

endmodule

// File: tb/tb_exu.sv
// tb_exu -- self-checking bench for exu: ALU vector table, directed
// multi-cycle sequences (stall, empty stage, alignment, async reset) and
// randomized transactions checked against a behavioural model.
module tb_exu;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    exu_if bus();

    exu dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

`ifdef EXU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [11:0] op;
        logic        rfm;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  mop;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] rkd;
        logic [31:0] pc;
    } txn_t;

    typedef struct {
        logic [11:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [150:0] pack(input txn_t t);
        return {t.op, t.rfm, t.a, t.b, t.mop, t.we, t.wa, t.rkd, t.pc};
    endfunction

    function automatic logic [150:0] junk();
        logic [159:0] j;
        j = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return j[150:0];
    endfunction

    function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        int sh;
        sa = a;
        sb = b;
        sh = int'(b % 32);
        case (op)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h004: return (sa < sb) ? 32'd1 : 32'd0;
            12'h008: return (a < b) ? 32'd1 : 32'd0;
            12'h010: return a & b;
            12'h020: return ~(a | b);
            12'h040: return a | b;
            12'h080: return a ^ b;
            12'h100: return a << sh;
            12'h200: return a >> sh;
            12'h400: return sa >>> sh;
            12'h800: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Full comparison of every observable output for an instruction held in EXE.
    task automatic check_stage(input txn_t t, input bit valid, input bit mok, input string tag);
        logic [31:0] res;
        logic [31:0] wd;
        logic [3:0]  we;
        bit ld, st, acc, mis, en;
        int sz;
        int off;
        res = ref_alu(t.op, t.a, t.b);
        ld  = t.rfm;
        st  = t.mop[2];
        acc = ld || st;
        sz  = int'(t.mop[1:0]);
        off = int'(res % 4);
        mis = ALIGN && acc && ((sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0));
        en  = valid && mok && acc && !mis;
        we  = 4'h0;
        if (en && st) begin
            if (sz == 0)      we = 4'(1 << off);
            else if (sz == 1) we = 4'(3 << ((off / 2) * 2));
            else if (sz == 2) we = 4'hF;
        end
        if (sz == 0)      wd = {24'h0, t.rkd[7:0]} * 32'h01010101;
        else if (sz == 1) wd = {16'h0, t.rkd[15:0]} * 32'h00010001;
        else              wd = t.rkd;
        chk({tag, ".valid"},   160'(bus.exe_to_mem_valid), 160'(valid));
        chk({tag, ".allowin"}, 160'(bus.exe_allowin),      160'(!valid || mok));
        chk({tag, ".en"},      160'(bus.data_sram_en),     160'(en));
        chk({tag, ".we"},      160'(bus.data_sram_we),     160'(we));
        chk({tag, ".ale"},     160'(bus.exe_ale),          160'(valid && mok && mis));
        chk({tag, ".rfzip"},   160'(bus.exe_rf_zip),
            160'({ld && valid, t.we && valid && !mis, t.wa, res}));
        if (valid) begin
            chk({tag, ".memzip"}, 160'(bus.exe_to_mem_zip),
                160'({t.rfm, t.mop, t.we && !mis, t.wa, res, t.pc}));
            chk({tag, ".addr"}, 160'(bus.data_sram_addr), 160'(res));
            if (st) chk({tag, ".wdata"}, 160'(bus.data_sram_wdata), 160'(wd));
        end
    endtask

    // Present t at a falling edge; returns #1 after the accepting rising edge,
    // with the ID side idle and mem_allowin = 1.
    task automatic load_txn(input txn_t t);
        @(negedge clk);
        bus.id_to_exe_valid = 1'b1;
        bus.id_to_exe_zip   = pack(t);
        bus.mem_allowin     = 1'b1;
        @(posedge clk);
        #1;
        bus.id_to_exe_valid = 1'b0;
        bus.id_to_exe_zip   = junk();
    endtask

    task automatic drain();
        @(negedge clk);
        bus.id_to_exe_valid = 1'b0;
        bus.mem_allowin     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t alu_txn(input logic [11:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] wa);
        txn_t t;
        t.op = op; t.rfm = 1'b0; t.a = a; t.b = b; t.mop = 4'b0000;
        t.we = 1'b1; t.wa = wa; t.rkd = 32'h0; t.pc = 32'h1C00_0000 + 32'(wa) * 4;
        return t;
    endfunction

    alu_vec_t vecs[$];
    txn_t     t;
    int       pulses;

    initial begin
        bus.id_to_exe_valid = 1'b0;
        bus.id_to_exe_zip   = '0;
        bus.mem_allowin     = 1'b1;

        // Reset state.
        #2;
        chk("rst.valid",   160'(bus.exe_to_mem_valid), 160'(0));
        chk("rst.en",      160'(bus.data_sram_en),     160'(0));
        chk("rst.we",      160'(bus.data_sram_we),     160'(0));
        chk("rst.ale",     160'(bus.exe_ale),          160'(0));
        chk("rst.rfwe",    160'(bus.exe_rf_zip[37]),   160'(0));
        chk("rst.allowin", 160'(bus.exe_allowin),      160'(1));
        @(negedge clk);
        resetn = 1'b1;

        // ALU table, including wrap-around and the all-zero op.
        vecs.push_back('{12'h001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000});
        vecs.push_back('{12'h001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001});
        vecs.push_back('{12'h002, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
        vecs.push_back('{12'h004, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
        vecs.push_back('{12'h004, 32'h00000001, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{12'h008, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        vecs.push_back('{12'h008, 32'h00000001, 32'hFFFFFFFF, 32'h00000001});
        vecs.push_back('{12'h010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
        vecs.push_back('{12'h020, 32'h0F0F0000, 32'h00F0000F, 32'hF000FFF0});
        vecs.push_back('{12'h040, 32'h12340000, 32'h00005678, 32'h12345678});
        vecs.push_back('{12'h080, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555});
        vecs.push_back('{12'h100, 32'h00000001, 32'h0000003F, 32'h80000000});
        vecs.push_back('{12'h200, 32'h80000000, 32'h00000004, 32'h08000000});
        vecs.push_back('{12'h400, 32'h80000000, 32'h00000004, 32'hF8000000});
        vecs.push_back('{12'h800, 32'h12345678, 32'hABCDE000, 32'hABCDE000});
        vecs.push_back('{12'h000, 32'h00000005, 32'h00000006, 32'h00000000});
        foreach (vecs[i]) begin
            t = alu_txn(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1));
            load_txn(t);
            chk($sformatf("alu%0d.result", i), 160'(bus.exe_rf_zip[31:0]), 160'(vecs[i].exp));
            check_stage(t, 1'b1, 1'b1, $sformatf("alu%0d", i));
        end
        drain();

        // st.b to 0x1003.
        t = alu_txn(12'h001, 32'h00001000, 32'h00000003, 5'd0);
        t.we = 1'b0; t.mop = 4'b0100; t.rkd = 32'h000000A5;
        load_txn(t);
        chk("stb.en",    160'(bus.data_sram_en),    160'(1));
        chk("stb.we",    160'(bus.data_sram_we),    160'(4'b1000));
        chk("stb.wdata", 160'(bus.data_sram_wdata), 160'(32'hA5A5A5A5));
        chk("stb.addr",  160'(bus.data_sram_addr),  160'(32'h00001003));
        drain();

        // Held load: three stall cycles, then a single request on release.
        t = alu_txn(12'h001, 32'h00002000, 32'h00000000, 5'd5);
        t.rfm = 1'b1; t.mop = 4'b0010;
        load_txn(t);
        pulses = 0;
        bus.mem_allowin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.id_to_exe_valid = 1'b1;
            bus.id_to_exe_zip   = junk();
            #1;
            if (bus.data_sram_en) pulses++;
            chk($sformatf("hold%0d.en", c),      160'(bus.data_sram_en),   160'(0));
            chk($sformatf("hold%0d.allowin", c), 160'(bus.exe_allowin),    160'(0));
            chk($sformatf("hold%0d.zip", c),     160'(bus.exe_to_mem_zip),
                160'({1'b1, 4'b0010, 1'b1, 5'd5, 32'h00002000, t.pc}));
            @(posedge clk);
            #1;
        end
        bus.id_to_exe_valid = 1'b0;
        bus.mem_allowin     = 1'b1;
        #1;
        if (bus.data_sram_en) pulses++;
        check_stage(t, 1'b1, 1'b1, "hold.rel");
        @(posedge clk);
        #1;
        if (bus.data_sram_en) pulses++;
        chk("hold.pulses", 160'(pulses), 160'(1));

        // Empty stage with stale rf_we = 1, waddr = 5.
        chk("empty.rfwe",  160'(bus.exe_rf_zip[37]),    160'(0));
        chk("empty.rfm",   160'(bus.exe_rf_zip[38]),    160'(0));
        chk("empty.valid", 160'(bus.exe_to_mem_valid),  160'(0));

        // ld.w at 0x1002.
        t = alu_txn(12'h001, 32'h00001000, 32'h00000002, 5'd9);
        t.rfm = 1'b1; t.mop = 4'b0010;
        load_txn(t);
        chk("ldw.en",    160'(bus.data_sram_en),       160'(!ALIGN));
        chk("ldw.ale",   160'(bus.exe_ale),            160'(ALIGN));
        chk("ldw.rfwe",  160'(bus.exe_to_mem_zip[69]), 160'(!ALIGN));
        chk("ldw.fwdwe", 160'(bus.exe_rf_zip[37]),     160'(!ALIGN));
        drain();
        chk("ldw.ale_after", 160'(bus.exe_ale), 160'(0));

        // Asynchronous reset while an instruction is held.
        t = alu_txn(12'h001, 32'h00003000, 32'h00000004, 5'd3);
        t.rfm = 1'b1; t.mop = 4'b0010;
        load_txn(t);
        bus.mem_allowin = 1'b0;
        #2;
        chk("arst.pre", 160'(bus.exe_to_mem_valid), 160'(1));
        resetn = 1'b0;
        #1;
        chk("arst.valid",   160'(bus.exe_to_mem_valid), 160'(0));
        chk("arst.en",      160'(bus.data_sram_en),     160'(0));
        chk("arst.rfwe",    160'(bus.exe_rf_zip[37]),   160'(0));
        chk("arst.allowin", 160'(bus.exe_allowin),      160'(1));
        @(negedge clk);
        resetn = 1'b1;
        t = alu_txn(12'h001, 32'h00000010, 32'h00000020, 5'd4);
        bus.id_to_exe_valid = 1'b1;
        bus.id_to_exe_zip   = pack(t);
        bus.mem_allowin     = 1'b1;
        @(posedge clk);
        #1;
        bus.id_to_exe_valid = 1'b0;
        check_stage(t, 1'b1, 1'b1, "arst.first");
        drain();

        // Randomized transactions with random stalls.
        for (int n = 0; n < 300; n++) begin
            int idx;
            int kind;
            int stalls;
            idx  = $urandom_range(0, 12);
            kind = $urandom_range(0, 2);
            t.op  = (idx == 12) ? 12'h000 : 12'(1 << idx);
            t.a   = $urandom;
            t.b   = $urandom;
            t.rfm = (kind == 1);
            t.mop = {1'($urandom), kind == 2, 2'($urandom_range(0, 2))};
            t.we  = 1'($urandom);
            t.wa  = 5'($urandom);
            t.rkd = $urandom;
            t.pc  = $urandom;
            load_txn(t);
            stalls = $urandom_range(0, 2);
            for (int c = 0; c < stalls; c++) begin
                bus.mem_allowin     = 1'b0;
                bus.id_to_exe_valid = 1'b1;
                bus.id_to_exe_zip   = junk();
                #1;
                check_stage(t, 1'b1, 1'b0, $sformatf("rnd%0d.s%0d", n, c));
                @(posedge clk);
                #1;
            end
            bus.id_to_exe_valid = 1'b0;
            bus.mem_allowin     = 1'b1;
            #1;
            check_stage(t, 1'b1, 1'b1, $sformatf("rnd%0d", n));
        end
        drain();
        chk("final.valid", 160'(bus.exe_to_mem_valid), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exu.md
EXU -- requirements
Module: EXU

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; resetn  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: exe_allowin  out  1; id_to_exe_valid  in  1; id_to_exe_zip  in  `ID2EXE_LEN (151), laid out as {alu_op[11:0], res_from_mem, alu_src1[31:0], alu_src2[31:0], mem_op[3:0], rf_we, rf_waddr[4:0], rkd_value[31:0], pc[31:0]}.
REQ-003 SHALL have ports: mem_allowin  in  1; exe_to_mem_valid  out  1; exe_to_mem_zip  out  `EXE2MEM_LEN (75), laid out as {res_from_mem, mem_op[3:0], rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0]}.
REQ-004 SHALL have ports: exe_rf_zip  out  39, laid out as {res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}; exe_ale  out  1, misaligned-access pulse.
REQ-005 SHALL have ports: data_sram_en  out  1; data_sram_we  out  4; data_sram_addr  out  32; data_sram_wdata  out  32.

Function
REQ-006 SHALL hold one valid bit, exe_valid: cleared by reset; loaded with id_to_exe_valid when exe_allowin is 1; held otherwise.
REQ-007 SHALL latch id_to_exe_zip only when id_to_exe_valid & exe_allowin; when holding, the payload SHALL stay unchanged.
REQ-008 SHALL drive ready_go = 1 (single-cycle stage); exe_allowin = ~exe_valid | mem_allowin; exe_to_mem_valid = exe_valid.
REQ-009 SHALL compute alu_result combinationally from the latched payload, with one-hot alu_op:
- bit0 add, bit1 sub, bit2 signed slt, bit3 unsigned sltu (both return 0/1);
- bit4 and, bit5 nor, bit6 or, bit7 xor;
- bit8 sll, bit9 srl, bit10 sra, shift amount alu_src2[4:0];
- bit11 pass alu_src2 (lu12i).
REQ-010 SHALL return alu_result = 0 when alu_op is all zero; all arithmetic SHALL be 32-bit wrap-around, with no overflow flag.
REQ-011 SHALL treat an access as: load when res_from_mem = 1; store when mem_op[2] = 1. Access size is mem_op[1:0]: 00 byte, 01 half, 10 word.
REQ-012 SHALL drive data_sram_en = exe_valid & mem_allowin & (load | store) & ~ale, so that a held instruction never issues a duplicate request.
REQ-013 SHALL drive data_sram_addr = alu_result.
REQ-014 SHALL generate data_sram_we, gated by data_sram_en (0 for loads):
- st.b: 4'b0001 << addr[1:0];
- st.h: 4'b0011 << {addr[1],1'b0};
- st.w: 4'b1111.
REQ-015 SHALL replicate store data: byte as {4{rkd[7:0]}}, half as {2{rkd[15:0]}}, word as rkd.
REQ-016 SHALL drive exe_rf_zip rf_we bit = rf_we & exe_valid, so an empty stage never produces a forwarding hit; the res_from_mem bit SHALL likewise be gated by exe_valid.
REQ-017 SHALL define ale = 0 unless the alignment check of REQ-020 is compiled in.

Reset
REQ-018 SHALL, while resetn = 0, force exe_valid = 0, exe_to_mem_valid = 0, data_sram_en = 0, data_sram_we = 0, exe_ale = 0 and the exe_rf_zip rf_we bit = 0; payload registers are don't-care.
REQ-019 SHALL, on reset asserted mid-transfer, drop the in-flight instruction, and SHALL accept new input on the first edge after release.

Configuration
REQ-020 SHALL, when macro EXU_ALIGN_CHECK_EN is defined:
- flag ale for half accesses with addr[0] = 1 and word accesses with addr[1:0] != 0;
- on ale, suppress the SRAM request and force the forwarded and outgoing rf_we to 0;
- pulse exe_ale high for exactly the cycle in which the instruction passes to MEM.
When the macro is undefined, exe_ale SHALL be tied 0 and misaligned accesses SHALL proceed unchecked.

Structure
REQ-021 SHALL take ID2EXE_LEN and EXE2MEM_LEN from the shared macros.h header, with EXE2MEM_LEN newly added = 75.
REQ-022 SHALL put the ALU in a sub-module named alu (ports alu_op[11:0], alu_src1, alu_src2, alu_result); EXU instantiates it once.

Verification
REQ-023 Add: alu_op = bit0, src1 = 0x7FFFFFFF, src2 = 1 -> alu_result = 0x80000000 on exe_rf_zip one cycle after handshake.
REQ-024 st.b, alu_result = 0x1003, rkd = 0x000000A5 -> data_sram_en = 1, we = 4'b1000, wdata = 0xA5A5A5A5, addr = 0x1003.
REQ-025 Held load: load accepted, mem_allowin = 0 for 3 cycles -> data_sram_en = 0 and exe_allowin = 0 for those cycles; en = 1 exactly once when mem_allowin rises; zip unchanged throughout.
REQ-026 Empty stage: exe_valid = 0 with stale payload rf_we = 1, waddr = 5 -> exe_rf_zip rf_we bit = 0.
REQ-027 EXU_ALIGN_CHECK_EN defined, ld.w at 0x1002 -> data_sram_en = 0, exe_ale = 1 for one cycle, outgoing rf_we = 0; macro undefined -> en = 1, exe_ale = 0.
REQ-028 Assert resetn = 0 with exe_valid = 1 -> exe_to_mem_valid = 0 immediately, without waiting for a clock edge.
